// File: rtl/picorv32_mem_responder.sv
// picorv32 native-bus memory responder.
// Word-organised SRAM with byte-strobe writes, programmable wait states,
// sticky out-of-range / protocol error flags and transfer counters.
module picorv32_mem_responder #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic        mem_instr,
  output logic        mem_ready,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  input  logic [3:0]  cfg_wait,
  output logic        oob_err,
  output logic        proto_err,
  output logic [31:0] xfer_cnt,
  output logic [31:0] fetch_cnt
);

  localparam int unsigned AW        = $clog2(MEM_WORDS);
  localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state;
  logic [3:0]  wcnt;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        req_instr;

  logic [31:0] mem [MEM_WORDS];

  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [3:0]  cur_wstrb;
  logic        cur_instr;
  logic        fire;
  logic [31:0] cur_off;
  logic        cur_in_range;
  logic [AW-1:0] cur_idx;

  // Select the request being completed this edge: live bus fields when a
  // zero-wait request is accepted straight from IDLE, latched fields otherwise.
  // `fire` marks the edge that enters RESP and performs the access.
  always_comb begin
    cur_addr  = req_addr;
    cur_wdata = req_wdata;
    cur_wstrb = req_wstrb;
    cur_instr = req_instr;
    fire      = 1'b0;
    if (state == S_IDLE) begin
      cur_addr  = mem_addr;
      cur_wdata = mem_wdata;
      cur_wstrb = mem_wstrb;
      cur_instr = mem_instr;
      fire      = mem_valid && (cfg_wait == 4'd0);
    end else if (state == S_WAIT) begin
      fire      = mem_valid && (wcnt == 4'd1);
    end
    cur_off      = cur_addr - BASE_ADDR;
    cur_in_range = {1'b0, cur_off} < MEM_BYTES;
    cur_idx      = cur_off[AW+1:2];
  end

  // Byte-strobed write commit; array is never reset, and a reset edge blocks the write.
  always_ff @(posedge clk) begin
    if (resetn && fire && cur_in_range && (cur_wstrb != 4'b0000)) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (cur_wstrb[i]) begin
          mem[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
        end
      end
    end
  end

  // Request FSM with registered outputs, flags and counters.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= S_IDLE;
      wcnt      <= '0;
      req_addr  <= '0;
      req_wdata <= '0;
      req_wstrb <= '0;
      req_instr <= 1'b0;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      oob_err   <= 1'b0;
      proto_err <= 1'b0;
      xfer_cnt  <= '0;
      fetch_cnt <= '0;
    end else begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      case (state)
        S_IDLE: begin
          if (mem_valid) begin
            req_addr  <= mem_addr;
            req_wdata <= mem_wdata;
            req_wstrb <= mem_wstrb;
            req_instr <= mem_instr;
            wcnt      <= cfg_wait;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!mem_valid) begin
            proto_err <= 1'b1;
            state     <= S_IDLE;
          end else begin
            wcnt <= wcnt - 4'd1;
          end
        end
        S_RESP: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      // Completion overrides the plain WAIT transitions chosen above.
      if (fire) begin
        state     <= S_RESP;
        mem_ready <= 1'b1;
        mem_rdata <= (cur_in_range && (cur_wstrb == 4'b0000)) ? mem[cur_idx] : '0;
        if (!cur_in_range) begin
          oob_err <= 1'b1;
        end
        xfer_cnt <= xfer_cnt + 32'd1;
        if (cur_instr) begin
          fetch_cnt <= fetch_cnt + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_picorv32_mem_responder.sv
// Self-checking bench for picorv32_mem_responder: directed scenarios plus
// randomized transfers checked against a word-array reference model.
module tb_picorv32_mem_responder;

  localparam int unsigned MW   = 64;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk;
  logic        resetn;
  logic        mem_valid;
  logic        mem_instr;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic [3:0]  cfg_wait;
  logic        oob_err;
  logic        proto_err;
  logic [31:0] xfer_cnt;
  logic [31:0] fetch_cnt;

  picorv32_mem_responder #(
    .MEM_WORDS(MW),
    .BASE_ADDR(BASE)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .mem_valid(mem_valid),
    .mem_instr(mem_instr),
    .mem_ready(mem_ready),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata),
    .cfg_wait (cfg_wait),
    .oob_err  (oob_err),
    .proto_err(proto_err),
    .xfer_cnt (xfer_cnt),
    .fetch_cnt(fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] model [MW];
  logic [31:0] exp_xfer;
  logic [31:0] exp_fetch;
  logic        exp_oob;
  logic        exp_proto;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_xfer"},  xfer_cnt,  exp_xfer);
    check({tag, "_fetch"}, fetch_cnt, exp_fetch);
    check({tag, "_oob"},   {31'b0, oob_err},   {31'b0, exp_oob});
    check({tag, "_proto"}, {31'b0, proto_err}, {31'b0, exp_proto});
  endtask

  // One complete transfer; optionally rewrites cfg_wait on cycle chg_at while pending.
  task automatic xfer(input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] wstrb, input logic instr, input logic [3:0] wt,
                      input int chg_at, input logic [3:0] chg_val);
    logic [31:0] off;
    logic [31:0] exp_rd;
    int          lat;
    bit          got;
    int          idx;
    off       = addr - BASE;
    exp_rd    = '0;
    cfg_wait  = wt;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = wstrb;
    mem_instr = instr;
    mem_valid = 1'b1;
    lat = 0;
    got = 0;
    while (!got && lat < 40) begin
      tick();
      lat++;
      if (mem_ready) begin
        got = 1;
      end else begin
        check("rdata_while_busy", mem_rdata, 32'h0);
        if (lat == chg_at) cfg_wait = chg_val;
        // Scramble the bus after acceptance; the latched request must win.
        if (lat == 1) begin
          mem_addr  = addr ^ 32'h0000_0004;
          mem_wdata = ~wdata;
          mem_wstrb = ~wstrb;
          mem_instr = ~instr;
        end
      end
    end
    if (off < MW * 4) begin
      idx = int'(off >> 2);
      if (wstrb == 4'b0000) begin
        exp_rd = model[idx];
      end else begin
        for (int b = 0; b < 4; b++)
          if (wstrb[b]) model[idx][8*b +: 8] = wdata[8*b +: 8];
      end
    end else begin
      exp_oob = 1'b1;
    end
    exp_xfer++;
    if (instr) exp_fetch++;
    check("ready_seen", {31'b0, got}, 32'd1);
    if (got) begin
      check("latency", 32'(lat), 32'(wt) + 32'd1);
      check("rdata", mem_rdata, exp_rd);
    end
    mem_valid = 1'b0;
    mem_instr = 1'b0;
    tick();
    check("ready_pulse_end", {31'b0, mem_ready}, 32'd0);
    check("rdata_after", mem_rdata, 32'h0);
  endtask

  // Request withdrawn after `hold` cycles of a wt-wait-state access.
  task automatic abort_req(input logic [31:0] addr, input logic [3:0] wt, input int hold);
    cfg_wait  = wt;
    mem_addr  = addr;
    mem_wdata = 32'hDEAD_BEEF;
    mem_wstrb = 4'hF;
    mem_valid = 1'b1;
    repeat (hold) begin
      tick();
      check("abort_no_ready_hold", {31'b0, mem_ready}, 32'd0);
    end
    mem_valid = 1'b0;
    repeat (8) begin
      tick();
      check("abort_no_ready", {31'b0, mem_ready}, 32'd0);
    end
    exp_proto = 1'b1;
  endtask

  initial begin
    logic [31:0] a;
    resetn    = 1'b0;
    mem_valid = 1'b0;
    mem_instr = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    cfg_wait  = '0;
    exp_xfer  = '0;
    exp_fetch = '0;
    exp_oob   = 1'b0;
    exp_proto = 1'b0;
    tick();
    tick();
    check("rst_ready", {31'b0, mem_ready}, 32'd0);
    check("rst_rdata", mem_rdata, 32'h0);
    check_status("rst");
    resetn = 1'b1;
    tick();

    // Preload every word so reads are fully predictable.
    for (int i = 0; i < MW; i++)
      xfer(BASE + 32'(4 * i), $urandom, 4'hF, 1'b0, 4'd0, 0, 4'd0);

    // Zero-wait write then read back.
    xfer(BASE + 32'h10, 32'hA5A5_1234, 4'hF, 1'b0, 4'd0, 0, 4'd0);
    xfer(BASE + 32'h10, 32'h0, 4'h0, 1'b0, 4'd0, 0, 4'd0);
    check("fixed_read_a5", model[4], 32'hA5A5_1234);
    check_status("basic");

    // Partial byte strobes.
    xfer(BASE + 32'h20, 32'h1122_3344, 4'hF, 1'b0, 4'd0, 0, 4'd0);
    xfer(BASE + 32'h20, 32'hFFFF_FFFF, 4'b0101, 1'b0, 4'd2, 0, 4'd0);
    xfer(BASE + 32'h20, 32'h0, 4'h0, 1'b0, 4'd0, 0, 4'd0);
    check("strobe_model", model[8], 32'h11FF_33FF);

    // Wait states on a fetch, cfg_wait raised mid-wait.
    xfer(BASE + 32'h30, 32'h0, 4'h0, 1'b1, 4'd3, 2, 4'd7);
    check_status("fetch");

    // Out-of-range: one past the end (would alias word 0) and just below base.
    a = BASE + MW * 4;
    xfer(a, 32'h0, 4'h0, 1'b0, 4'd0, 0, 4'd0);
    xfer(a, 32'hCAFE_F00D, 4'hF, 1'b0, 4'd1, 0, 4'd0);
    xfer(BASE - 32'd4, 32'h0, 4'h0, 1'b0, 4'd0, 0, 4'd0);
    xfer(BASE, 32'h0, 4'h0, 1'b0, 4'd0, 0, 4'd0);
    xfer(BASE + MW * 4 - 32'd4, 32'h0, 4'h0, 1'b0, 4'd0, 0, 4'd0);
    check_status("oob");

    // Protocol fault: valid dropped during wait states.
    abort_req(BASE + 32'h40, 4'd5, 2);
    check_status("proto");
    xfer(BASE + 32'h40, 32'h0, 4'h0, 1'b0, 4'd0, 0, 4'd0);

    // Reset during wait states of a write: write abandoned, state cleared.
    cfg_wait  = 4'd5;
    mem_addr  = BASE + 32'h50;
    mem_wdata = ~model[20];
    mem_wstrb = 4'hF;
    mem_valid = 1'b1;
    tick();
    tick();
    resetn    = 1'b0;
    mem_valid = 1'b0;
    tick();
    exp_xfer  = '0;
    exp_fetch = '0;
    exp_oob   = 1'b0;
    exp_proto = 1'b0;
    check("rst2_ready", {31'b0, mem_ready}, 32'd0);
    check("rst2_rdata", mem_rdata, 32'h0);
    check_status("rst2");
    resetn = 1'b1;
    tick();
    xfer(BASE + 32'h50, 32'h0, 4'h0, 1'b0, 4'd0, 0, 4'd0);
    check_status("post_rst");

    // Randomized traffic, including unaligned low bits and stray addresses.
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 9) == 0)
        a = $urandom;
      else
        a = BASE + 32'(4 * $urandom_range(0, MW - 1)) + 32'($urandom_range(0, 3));
      xfer(a, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 4)), 0, 4'd0);
    end
    check_status("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
